sd_init_sequencer: RTL and testbench
====================================

Name: sd_init_sequencer

Overview:
Drives spiCommMaster through the SD-card SPI-mode power-up and initialization sequence: CMD0, CMD8, then CMD55/ACMD41 until ready, then CMD58. It supplies command fields, commStart and readMode, checks every response, and classifies the card (v1/v2, SDSC/SDHC). It sits between the top-level control in main.v and spiCommMaster. It owns spiClockEn and the master's reset during initialization.

Parameters:
WARMUP_CYCLES, 20480, cpuClock cycles of free-running SCLK with CS high before CMD0 (80 SPI clocks at cpuClock/256)
MAX_RETRY, 1000, maximum CMD55/ACMD41 iterations before the timeout error
GAP_CYCLES, 16, idle cpuClock cycles between commands after commFinish falls

Ports:
cpuClock  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  rising edge starts initialization (accepted in IDLE, DONE or ERROR)
busy  out  1  high from accepted start until DONE or ERROR
initDone  out  1  high in DONE
initError  out  1  high in ERROR
errorCode  out  4  0 none, 1 comm error, 2 bad R1, 3 CMD8 echo mismatch, 4 ACMD41 timeout, 5 OCR power-up bit clear
cardV2  out  1  card answered CMD8 correctly
cardHC  out  1  CCS bit (OCR[30]) from CMD58; 0 for v1 cards
commReset  out  1  reset to spiCommMaster
spiClockEn  out  1  to spiCommMaster
commStart  out  1  to spiCommMaster
cmdTransmitBit  out  1  constant 1
cmdIndex  out  6  command index
cmdArgument  out  32  command argument
readMode  out  2  00 single byte, 10 wide (5 bytes)
commFinish  in  1  from spiCommMaster
commErrorInterrupt  in  1  from spiCommMaster
readResponse  in  40  from spiCommMaster; R1 is readResponse[7:0] in single mode and readResponse[39:32] in wide mode

Behaviour:
- Reset, asynchronous: state IDLE. Outputs reset as follows:
  - All flags, errorCode, cardV2, cardHC, commStart, spiClockEn: 0.
  - commReset: 1.
  - cmdIndex, cmdArgument, readMode: 0. cmdTransmitBit: 1.
- Start edge detect uses a registered copy of start. A new start in DONE or ERROR clears flags, errorCode, cardV2 and cardHC.
- States: IDLE, WARMUP, ISSUE, WAIT, CHECK, GAP, DONE, ERROR. The current command (C0, C8, C55, C41, C58) is held in a separate register.
- IDLE: commReset=1. On start, move to WARMUP, load the counter with WARMUP_CYCLES, drive commReset=0 and spiClockEn=1.
- WARMUP: decrement the counter. At 0, set command=C0 and go to ISSUE.
- ISSUE: drive cmdIndex, cmdArgument and readMode from a command table, stable from this cycle. Set commStart=1 the next cycle, then go to WAIT. Command table:
  - C0: index 0, argument 0, readMode 00.
  - C8: index 8, argument 0x000001AA, readMode 10.
  - C55: index 55, argument 0, readMode 00.
  - C41: index 41, argument 0x40000000 if cardV2 else 0, readMode 00.
  - C58: index 58, argument 0, readMode 10.
- WAIT: hold commStart=1 until commFinish=1. Then latch readResponse, drop commStart and go to CHECK.
- commErrorInterrupt=1 in any non-IDLE/DONE/ERROR state takes priority over everything: go to ERROR with code 1.
- CHECK, one cycle:
  - C0: R1==0x01 -> C8; otherwise code 2.
  - C8:
    - R1==0x01 and resp[11:0]==0x1AA -> cardV2=1, then C55.
    - R1==0x01 with an echo mismatch -> code 3.
    - R1==0x05 (illegal command) -> cardV2=0, then C55.
    - Any other value -> code 2.
  - C55: R1 of 0x00 or 0x01 -> C41; otherwise code 2.
  - C41:
    - R1==0x00: go to C58 if cardV2, else DONE.
    - R1==0x01: increment the retry counter. If the count reaches MAX_RETRY, code 4; otherwise C55.
    - Any other value: code 2.
  - C58:
    - R1 other than 0x00 -> code 2.
    - resp[31]==0 -> code 5.
    - Otherwise set cardHC=resp[30] and go to DONE.
- GAP: entered after a passing CHECK that leads to another command. Wait until commFinish==0, then count GAP_CYCLES, then go to ISSUE.
- The retry counter clears on start and on every entry to C0.
- DONE: initDone=1, busy=0, spiClockEn stays 1, commReset=0.
- ERROR: initError=1, busy=0, commStart=0, commReset=1 (the master leaves its sticky error state), spiClockEn=0.
- start while busy: ignored.
- reset asserted mid-command: immediate IDLE; commReset=1 aborts the master.

Test Plan:
1. v2 SDHC model: R1 0x01; CMD8 0x01_000001AA; ACMD41 returns 0x01 twice, then 0x00; CMD58 0x00_C0FF8000 -> initDone=1, cardV2=1, cardHC=1, 3 CMD55/CMD41 pairs issued, 20480-cycle warmup measured before the first commStart.
2. v1 card: CMD8 R1=0x05 -> cardV2=0; CMD41 argument 0; no CMD58 issued; initDone=1, cardHC=0.
3. CMD8 echo 0x01_000001AB -> initError=1, errorCode=3, commReset=1, busy=0.
4. ACMD41 always 0x01, MAX_RETRY=4 -> exactly 4 CMD41 issued, errorCode=4.
5. commErrorInterrupt pulsed during CMD0 WAIT -> ERROR, errorCode=1. A new start edge then yields a full successful sequence with flags cleared.
6. reset asserted during WAIT of C55 -> next cycle: commStart=0, commReset=1, spiClockEn=0, busy=0. A later start re-runs the warmup.

Source files
------------

// File: rtl/sd_init_sequencer_if.sv
// Command/response bus between the SD init sequencer and spiCommMaster.
interface sd_init_sequencer_if;
  logic        commReset;
  logic        spiClockEn;
  logic        commStart;
  logic        cmdTransmitBit;
  logic [5:0]  cmdIndex;
  logic [31:0] cmdArgument;
  logic [1:0]  readMode;
  logic        commFinish;
  logic        commErrorInterrupt;
  logic [39:0] readResponse;

  // Sequencer side.
  modport master (
    output commReset, spiClockEn, commStart, cmdTransmitBit, cmdIndex, cmdArgument, readMode,
    input  commFinish, commErrorInterrupt, readResponse
  );

  // spiCommMaster side.
  modport slave (
    input  commReset, spiClockEn, commStart, cmdTransmitBit, cmdIndex, cmdArgument, readMode,
    output commFinish, commErrorInterrupt, readResponse
  );
endinterface

// File: rtl/sd_init_sequencer.sv
// SD-card SPI-mode power-up sequencer: CMD0, CMD8, CMD55/ACMD41 until ready, CMD58.
// Drives spiCommMaster command fields, classifies the card and reports errors.
module sd_init_sequencer #(
  parameter int unsigned WARMUP_CYCLES = 20480,
  parameter int unsigned MAX_RETRY     = 1000,
  parameter int unsigned GAP_CYCLES    = 16
) (
  input  logic                       cpuClock,
  input  logic                       reset,
  input  logic                       start,
  output logic                       busy,
  output logic                       initDone,
  output logic                       initError,
  output logic [3:0]                 errorCode,
  output logic                       cardV2,
  output logic                       cardHC,
  sd_init_sequencer_if.master        comm
);
  localparam int unsigned RetryW = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    StIdle, StWarmup, StIssue, StWait, StCheck, StGap, StDone, StError
  } state_e;

  typedef enum logic [2:0] {CmdC0, CmdC8, CmdC55, CmdC41, CmdC58} cmd_e;

  state_e            state_q, state_d;
  cmd_e              cmd_q, cmd_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [39:0]       resp_q, resp_d;
  logic              start_q;
  logic              busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [3:0]        code_q, code_d;
  logic              v2_q, v2_d, hc_q, hc_d;
  logic              comm_reset_q, comm_reset_d, clk_en_q, clk_en_d, comm_start_q, comm_start_d;
  logic [5:0]        index_q, index_d;
  logic [31:0]       arg_q, arg_d;
  logic [1:0]        mode_q, mode_d;

  logic       start_edge;
  logic [7:0] r1;
  logic       err_req;
  logic [3:0] err_code;
  logic       unused_resp_bits;

  assign start_edge       = start & ~start_q;
  // R1 sits in the top byte for 5-byte reads and the bottom byte for single reads.
  assign r1               = mode_q[1] ? resp_q[39:32] : resp_q[7:0];
  assign unused_resp_bits = ^resp_q[29:12];

  assign busy                = busy_q;
  assign initDone            = done_q;
  assign initError           = error_q;
  assign errorCode           = code_q;
  assign cardV2              = v2_q;
  assign cardHC              = hc_q;
  assign comm.commReset      = comm_reset_q;
  assign comm.spiClockEn     = clk_en_q;
  assign comm.commStart      = comm_start_q;
  assign comm.cmdTransmitBit = 1'b1;
  assign comm.cmdIndex       = index_q;
  assign comm.cmdArgument    = arg_q;
  assign comm.readMode       = mode_q;

  // Next-state and registered-output logic for the init sequence.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    cnt_d        = cnt_q;
    retry_d      = retry_q;
    resp_d       = resp_q;
    busy_d       = busy_q;
    done_d       = done_q;
    error_d      = error_q;
    code_d       = code_q;
    v2_d         = v2_q;
    hc_d         = hc_q;
    comm_reset_d = comm_reset_q;
    clk_en_d     = clk_en_q;
    comm_start_d = comm_start_q;
    index_d      = index_q;
    arg_d        = arg_q;
    mode_d       = mode_q;
    err_req      = 1'b0;
    err_code     = 4'd0;

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (state_q == StIdle) comm_reset_d = 1'b1;
        if (start_edge) begin
          state_d      = StWarmup;
          cnt_d        = WARMUP_CYCLES;
          retry_d      = '0;
          comm_reset_d = 1'b0;
          clk_en_d     = 1'b1;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          error_d      = 1'b0;
          code_d       = 4'd0;
          v2_d         = 1'b0;
          hc_d         = 1'b0;
        end
      end
      StWarmup: begin
        if (cnt_q == 32'd0) begin
          cmd_d   = CmdC0;
          retry_d = '0;
          state_d = StIssue;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      StIssue: begin
        comm_start_d = 1'b1;
        state_d      = StWait;
      end
      StWait: begin
        if (comm.commFinish) begin
          resp_d       = comm.readResponse;
          comm_start_d = 1'b0;
          state_d      = StCheck;
        end
      end
      StCheck: begin
        state_d = StGap;
        cnt_d   = GAP_CYCLES;
        case (cmd_q)
          CmdC0: begin
            if (r1 == 8'h01) cmd_d = CmdC8;
            else begin err_req = 1'b1; err_code = 4'd2; end
          end
          CmdC8: begin
            if (r1 == 8'h01 && resp_q[11:0] == 12'h1AA) begin
              v2_d  = 1'b1;
              cmd_d = CmdC55;
            end else if (r1 == 8'h01) begin
              err_req = 1'b1; err_code = 4'd3;
            end else if (r1 == 8'h05) begin
              v2_d  = 1'b0;
              cmd_d = CmdC55;
            end else begin
              err_req = 1'b1; err_code = 4'd2;
            end
          end
          CmdC55: begin
            if (r1 == 8'h00 || r1 == 8'h01) cmd_d = CmdC41;
            else begin err_req = 1'b1; err_code = 4'd2; end
          end
          CmdC41: begin
            if (r1 == 8'h00) begin
              if (v2_q) begin
                cmd_d = CmdC58;
              end else begin
                state_d = StDone;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end
            end else if (r1 == 8'h01) begin
              retry_d = retry_q + RetryW'(1);
              if (retry_q + RetryW'(1) == RetryW'(MAX_RETRY)) begin
                err_req = 1'b1; err_code = 4'd4;
              end else begin
                cmd_d = CmdC55;
              end
            end else begin
              err_req = 1'b1; err_code = 4'd2;
            end
          end
          CmdC58: begin
            if (r1 != 8'h00) begin
              err_req = 1'b1; err_code = 4'd2;
            end else if (!resp_q[31]) begin
              err_req = 1'b1; err_code = 4'd5;
            end else begin
              hc_d    = resp_q[30];
              state_d = StDone;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
          default: begin
            err_req = 1'b1; err_code = 4'd2;
          end
        endcase
      end
      StGap: begin
        // The count only advances once the master has dropped commFinish.
        if (!comm.commFinish) begin
          if (cnt_q == 32'd0) state_d = StIssue;
          else cnt_d = cnt_q - 32'd1;
        end
      end
    endcase

    // A master error overrides any decision made by the active state.
    if (comm.commErrorInterrupt &&
        (state_q inside {StWarmup, StIssue, StWait, StCheck, StGap})) begin
      err_req  = 1'b1;
      err_code = 4'd1;
    end

    if (err_req) begin
      state_d      = StError;
      code_d       = err_code;
      error_d      = 1'b1;
      busy_d       = 1'b0;
      comm_start_d = 1'b0;
      comm_reset_d = 1'b1;
      clk_en_d     = 1'b0;
    end

    // Command fields are loaded on entry to ISSUE so they are stable before commStart.
    if (state_d == StIssue && state_q != StIssue) begin
      index_d = 6'd0;
      arg_d   = 32'd0;
      mode_d  = 2'b00;
      case (cmd_d)
        CmdC8:   begin index_d = 6'd8;  arg_d = 32'h0000_01AA; mode_d = 2'b10; end
        CmdC55:  index_d = 6'd55;
        CmdC41:  begin index_d = 6'd41; arg_d = v2_q ? 32'h4000_0000 : 32'd0; end
        CmdC58:  begin index_d = 6'd58; mode_d = 2'b10; end
        default: index_d = 6'd0;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge cpuClock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cmd_q        <= CmdC0;
      cnt_q        <= '0;
      retry_q      <= '0;
      resp_q       <= '0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      code_q       <= 4'd0;
      v2_q         <= 1'b0;
      hc_q         <= 1'b0;
      comm_reset_q <= 1'b1;
      clk_en_q     <= 1'b0;
      comm_start_q <= 1'b0;
      index_q      <= '0;
      arg_q        <= '0;
      mode_q       <= '0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      resp_q       <= resp_d;
      start_q      <= start;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      code_q       <= code_d;
      v2_q         <= v2_d;
      hc_q         <= hc_d;
      comm_reset_q <= comm_reset_d;
      clk_en_q     <= clk_en_d;
      comm_start_q <= comm_start_d;
      index_q      <= index_d;
      arg_q        <= arg_d;
      mode_q       <= mode_d;
    end
  end
endmodule

// File: tb/tb_sd_init_sequencer.sv
// Bench for sd_init_sequencer: a behavioural SD card answers commands, and a reference
// model derives the expected command list and final status from the card's personality.
module tb_sd_init_sequencer;
  localparam int unsigned TbWarmup = 64;
  localparam int unsigned TbRetry  = 4;
  localparam int unsigned TbGap    = 16;

  logic       cpuClock = 1'b0;
  logic       reset;
  logic       start;
  logic       busy, initDone, initError, cardV2, cardHC;
  logic [3:0] errorCode;

  sd_init_sequencer_if bus();

  sd_init_sequencer #(
    .WARMUP_CYCLES(TbWarmup),
    .MAX_RETRY    (TbRetry),
    .GAP_CYCLES   (TbGap)
  ) dut (
    .cpuClock (cpuClock),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .initDone (initDone),
    .initError(initError),
    .errorCode(errorCode),
    .cardV2   (cardV2),
    .cardHC   (cardHC),
    .comm     (bus)
  );

  always #5 cpuClock = ~cpuClock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Card personality.
  logic [7:0]  sc_c0_r1;
  logic [7:0]  sc_c8_r1;
  logic [11:0] sc_echo;
  int          sc_busy_n;
  logic        sc_pwr, sc_hc;
  bit          mute = 1'b0;
  int          a41_seen = 0;

  // Observed and expected command streams.
  logic [5:0]  obs_idx[$], exp_idx[$];
  logic [31:0] obs_arg[$], exp_arg[$];
  logic [1:0]  obs_mode[$], exp_mode[$];
  logic        exp_done, exp_v2, exp_hc;
  logic [3:0]  exp_code;

  task automatic set_sc(input logic [7:0] c0, input logic [7:0] c8, input logic [11:0] echo,
                        input int busy_n, input logic pwr, input logic hc);
    sc_c0_r1 = c0; sc_c8_r1 = c8; sc_echo = echo;
    sc_busy_n = busy_n; sc_pwr = pwr; sc_hc = hc;
  endtask

  function automatic logic [39:0] card_resp(input logic [5:0] idx, input logic [1:0] mode);
    logic [7:0]  r;
    logic [31:0] low;
    low = $urandom();
    case (idx)
      6'd0:    r = sc_c0_r1;
      6'd8:    begin r = sc_c8_r1; low = {low[31:12], sc_echo}; end
      6'd55:   r = 8'h01;
      6'd41:   r = (a41_seen < sc_busy_n) ? 8'h01 : 8'h00;
      6'd58:   begin r = 8'h00; low = {sc_pwr, sc_hc, low[29:0]}; end
      default: r = 8'hFF;
    endcase
    return (mode == 2'b10) ? {r, low} : {low, r};
  endfunction

  function automatic void push_exp(input logic [5:0] i, input logic [31:0] a, input logic [1:0] m);
    exp_idx.push_back(i); exp_arg.push_back(a); exp_mode.push_back(m);
  endfunction

  // Reference: walk the init protocol against the card personality.
  function automatic void build_expected();
    logic v2;
    v2 = 1'b0;
    exp_idx.delete(); exp_arg.delete(); exp_mode.delete();
    exp_done = 1'b0; exp_code = 4'd0; exp_v2 = 1'b0; exp_hc = 1'b0;
    push_exp(6'd0, 32'd0, 2'b00);
    if (sc_c0_r1 != 8'h01) begin exp_code = 4'd2; return; end
    push_exp(6'd8, 32'h1AA, 2'b10);
    if (sc_c8_r1 == 8'h01 && sc_echo == 12'h1AA) v2 = 1'b1;
    else if (sc_c8_r1 == 8'h01) begin exp_code = 4'd3; return; end
    else if (sc_c8_r1 != 8'h05) begin exp_code = 4'd2; return; end
    exp_v2 = v2;
    for (int i = 0; i < 64; i++) begin
      push_exp(6'd55, 32'd0, 2'b00);
      push_exp(6'd41, v2 ? 32'h4000_0000 : 32'd0, 2'b00);
      if (i >= sc_busy_n) break;
      if (i + 1 == int'(TbRetry)) begin exp_code = 4'd4; return; end
    end
    if (v2) begin
      push_exp(6'd58, 32'd0, 2'b10);
      if (!sc_pwr) begin exp_code = 4'd5; return; end
      exp_hc = sc_hc;
    end
    exp_done = 1'b1;
  endfunction

  // Behavioural spiCommMaster + card: answers each commStart after a random latency.
  initial begin : responder
    bus.commFinish   = 1'b0;
    bus.readResponse = '0;
    forever begin
      @(posedge cpuClock); #1;
      if (!reset && bus.commStart && !bus.commFinish) begin
        obs_idx.push_back(bus.cmdIndex);
        obs_arg.push_back(bus.cmdArgument);
        obs_mode.push_back(bus.readMode);
        if (!mute) begin
          repeat ($urandom_range(1, 6)) @(posedge cpuClock);
          #1;
          bus.readResponse = card_resp(bus.cmdIndex, bus.readMode);
          bus.commFinish   = 1'b1;
          if (bus.cmdIndex == 6'd41) a41_seen++;
        end
        for (int k = 0; k < 400 && bus.commStart; k++) begin
          @(posedge cpuClock); #1;
        end
        repeat ($urandom_range(0, 3)) @(posedge cpuClock);
        #1;
        bus.commFinish = 1'b0;
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge cpuClock); #1;
    start = 1'b0;
  endtask

  task automatic run_scenario(input string name);
    int warm;
    int cyc;
    obs_idx.delete(); obs_arg.delete(); obs_mode.delete();
    a41_seen = 0;
    build_expected();
    pulse_start();
    check_eq({name, " busy after start"}, busy, 1);
    check_eq({name, " flags clear"}, {initDone, initError, errorCode, cardV2, cardHC}, 0);
    warm = 0;
    while (!bus.commStart && warm < int'(TbWarmup) + 100) begin
      @(posedge cpuClock); #1;
      warm++;
    end
    check_eq({name, " warmup length"},
             (warm >= int'(TbWarmup) && warm <= int'(TbWarmup) + 4), 1);
    cyc = 0;
    while (busy && cyc < 20000) begin
      @(posedge cpuClock); #1;
      cyc++;
    end
    check_eq({name, " sequence ends"}, busy, 0);
    repeat (10) @(posedge cpuClock);
    #1;
    check_eq({name, " cmd count"}, obs_idx.size(), exp_idx.size());
    for (int i = 0; i < exp_idx.size() && i < obs_idx.size(); i++) begin
      check_eq($sformatf("%s cmd%0d index", name, i), obs_idx[i], exp_idx[i]);
      check_eq($sformatf("%s cmd%0d arg", name, i), obs_arg[i], exp_arg[i]);
      check_eq($sformatf("%s cmd%0d mode", name, i), obs_mode[i], exp_mode[i]);
    end
    check_eq({name, " initDone"}, initDone, exp_done);
    check_eq({name, " initError"}, initError, !exp_done);
    check_eq({name, " errorCode"}, errorCode, exp_code);
    check_eq({name, " cardV2"}, cardV2, exp_v2);
    check_eq({name, " cardHC"}, cardHC, exp_hc);
    check_eq({name, " commReset"}, bus.commReset, !exp_done);
    check_eq({name, " spiClockEn"}, bus.spiClockEn, exp_done);
    check_eq({name, " commStart idle"}, bus.commStart, 0);
  endtask

  initial begin : main
    int cyc;
    reset = 1'b1;
    start = 1'b0;
    bus.commErrorInterrupt = 1'b0;
    set_sc(8'h01, 8'h01, 12'h1AA, 0, 1'b1, 1'b0);
    repeat (3) @(posedge cpuClock);
    #1;
    check_eq("reset status", {busy, initDone, initError, errorCode, cardV2, cardHC}, 0);
    check_eq("reset commReset", bus.commReset, 1);
    check_eq("reset spiClockEn", bus.spiClockEn, 0);
    check_eq("reset commStart", bus.commStart, 0);
    check_eq("reset cmd fields", {bus.cmdIndex, bus.cmdArgument, bus.readMode}, 0);
    check_eq("reset cmdTransmitBit", bus.cmdTransmitBit, 1);
    reset = 1'b0;
    repeat (2) @(posedge cpuClock);
    #1;

    set_sc(8'h01, 8'h01, 12'h1AA, 2, 1'b1, 1'b1);
    run_scenario("v2hc");
    set_sc(8'h01, 8'h05, 12'h000, 1, 1'b1, 1'b1);
    run_scenario("v1");
    set_sc(8'h01, 8'h01, 12'h1AB, 0, 1'b1, 1'b0);
    run_scenario("echo_bad");
    set_sc(8'h01, 8'h01, 12'h1AA, 99, 1'b1, 1'b0);
    run_scenario("acmd41_timeout");

    // Master error during CMD0, then a clean restart.
    mute = 1'b1;
    pulse_start();
    cyc = 0;
    while (!bus.commStart && cyc < 1000) begin
      @(posedge cpuClock); #1;
      cyc++;
    end
    check_eq("commerr cmd0 issued", bus.commStart && bus.cmdIndex == 6'd0, 1);
    repeat (2) @(posedge cpuClock);
    #1;
    bus.commErrorInterrupt = 1'b1;
    @(posedge cpuClock); #1;
    bus.commErrorInterrupt = 1'b0;
    check_eq("commerr initError", initError, 1);
    check_eq("commerr errorCode", errorCode, 4'd1);
    check_eq("commerr busy", busy, 0);
    check_eq("commerr commStart", bus.commStart, 0);
    check_eq("commerr commReset", bus.commReset, 1);
    check_eq("commerr spiClockEn", bus.spiClockEn, 0);
    repeat (10) @(posedge cpuClock);
    #1;
    mute = 1'b0;
    set_sc(8'h01, 8'h01, 12'h1AA, 1, 1'b1, 1'b0);
    run_scenario("after_commerr");

    // Reset in the middle of a CMD55 transfer.
    set_sc(8'h01, 8'h01, 12'h1AA, 1, 1'b1, 1'b1);
    a41_seen = 0;
    pulse_start();
    cyc = 0;
    while (!(bus.commStart && bus.cmdIndex == 6'd55) && cyc < 2000) begin
      @(posedge cpuClock); #1;
      cyc++;
    end
    check_eq("midreset cmd55 reached", bus.commStart && bus.cmdIndex == 6'd55, 1);
    reset = 1'b1;
    @(posedge cpuClock); #1;
    check_eq("midreset commStart", bus.commStart, 0);
    check_eq("midreset commReset", bus.commReset, 1);
    check_eq("midreset spiClockEn", bus.spiClockEn, 0);
    check_eq("midreset busy", busy, 0);
    reset = 1'b0;
    repeat (20) @(posedge cpuClock);
    #1;
    run_scenario("after_reset");

    for (int s = 0; s < 12; s++) begin
      sc_c0_r1 = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'h01;
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: begin sc_c8_r1 = 8'h01; sc_echo = 12'h1AA; end
        5, 6:          begin sc_c8_r1 = 8'h05; sc_echo = 12'($urandom()); end
        7:       begin sc_c8_r1 = 8'h01; sc_echo = 12'h1AA ^ (12'h1 << $urandom_range(0, 11)); end
        default: begin sc_c8_r1 = 8'h09; sc_echo = 12'h1AA; end
      endcase
      sc_busy_n = $urandom_range(0, 5);
      sc_pwr    = ($urandom_range(0, 4) != 0);
      sc_hc     = 1'($urandom_range(0, 1));
      run_scenario($sformatf("rnd%0d", s));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
